// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU datapath:
// ALU control codes, main-decoder classes, immediate opcodes and the decode helper.
package cpu16_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [3:0] OP_ANDI = 4'b0100;
    localparam logic [3:0] OP_ORI  = 4'b0101;
    localparam logic [3:0] OP_XORI = 4'b0110;
    localparam logic [3:0] OP_SLTI = 4'b0111;
    localparam logic [3:0] OP_NORI = 4'b1000;

    // Unrecognised immediate opcodes fall back to ADD so address arithmetic still works.
    function automatic logic [3:0] alu_decode(input logic [1:0] aluop,
                                              input logic [1:0] funct,
                                              input logic [3:0] opcode);
        logic [3:0] ctrl;
        ctrl = ALU_ADD;
        case (aluop)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    2'b00:   ctrl = ALU_ADD;
                    2'b01:   ctrl = ALU_SUB;
                    2'b10:   ctrl = ALU_AND;
                    default: ctrl = ALU_OR;
                endcase
            end
            default: begin
                case (opcode)
                    OP_ANDI: ctrl = ALU_AND;
                    OP_ORI:  ctrl = ALU_OR;
                    OP_XORI: ctrl = ALU_XOR;
                    OP_SLTI: ctrl = ALU_SLT;
                    OP_NORI: ctrl = ALU_NOR;
                    default: ctrl = ALU_ADD;
                endcase
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_mem_stage_if.sv
// Operand, control and result bundle between decode/register file and the
// execute-and-memory stage.
interface alu_mem_stage_if
    import cpu16_pkg::*;
();
    logic [1:0]        ALUOp;
    logic [1:0]        Funct;
    logic [3:0]        Opcode;
    logic [WORD_W-1:0] A;
    logic [WORD_W-1:0] B;
    logic              CarryIn;
    logic              MemWrite;
    logic              MemRead;
    logic [WORD_W-1:0] WriteData;
    logic [3:0]        ALUCtrl;
    logic [WORD_W-1:0] Result;
    logic              Zero;
    logic              Overflow;
    logic              CarryOut;
    logic [WORD_W-1:0] ReadData;

    modport master (
        output ALUOp, Funct, Opcode, A, B, CarryIn, MemWrite, MemRead, WriteData,
        input  ALUCtrl, Result, Zero, Overflow, CarryOut, ReadData
    );

    modport slave (
        input  ALUOp, Funct, Opcode, A, B, CarryIn, MemWrite, MemRead, WriteData,
        output ALUCtrl, Result, Zero, Overflow, CarryOut, ReadData
    );
endinterface

// File: rtl/alu_mem_stage_alu16_core.sv
// Combinational 16-bit ALU with zero, signed-overflow and carry/no-borrow flags.
module alu16_core
    import cpu16_pkg::*;
(
    input  logic [3:0]        ctrl_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] result_o,
    output logic              zero_o,
    output logic              ovf_o,
    output logic              cout_o
);
    logic [WORD_W:0] sum;
    logic [WORD_W:0] diff;
    logic            add_ovf;
    logic            sub_ovf;

    assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};
    assign diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WORD_W{1'b0}}, 1'b1};

    assign add_ovf = (a_i[WORD_W-1] == b_i[WORD_W-1]) && (sum[WORD_W-1] != a_i[WORD_W-1]);
    assign sub_ovf = (a_i[WORD_W-1] != b_i[WORD_W-1]) && (diff[WORD_W-1] != a_i[WORD_W-1]);

    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        cout_o   = 1'b0;
        case (ctrl_i)
            ALU_ADD: begin
                result_o = sum[WORD_W-1:0];
                cout_o   = sum[WORD_W];
                ovf_o    = add_ovf;
            end
            ALU_SUB: begin
                result_o = diff[WORD_W-1:0];
                cout_o   = diff[WORD_W];
                ovf_o    = sub_ovf;
            end
            // Signed less-than: true sign of A-B is the raw sign corrected by overflow.
            ALU_SLT: result_o = {{(WORD_W-1){1'b0}}, diff[WORD_W-1] ^ sub_ovf};
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_mem_stage.sv
// Execute-and-memory stage: ALU control decode, 16-bit ALU, and a word-organised
// data memory addressed by the ALU result (byte address, word access).
module alu_mem_stage
    import cpu16_pkg::*;
#(
    parameter int MEM_WORDS = 128
) (
    input  logic           Clock,
    input  logic           Reset,
    alu_mem_stage_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [3:0]        alu_ctrl;
    logic [WORD_W-1:0] result;
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] mem_q [MEM_WORDS];
    logic              unused_addr_bits;

    assign alu_ctrl = alu_decode(bus.ALUOp, bus.Funct, bus.Opcode);

    alu16_core u_alu (
        .ctrl_i   (alu_ctrl),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .cin_i    (bus.CarryIn),
        .result_o (result),
        .zero_o   (bus.Zero),
        .ovf_o    (bus.Overflow),
        .cout_o   (bus.CarryOut)
    );

    assign bus.ALUCtrl = alu_ctrl;
    assign bus.Result  = result;

    // Byte address, word access: bit 0 and bits above the index width are dropped.
    assign word_idx         = result[AW:1];
    assign unused_addr_bits = ^{result[WORD_W-1:AW+1], result[0]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.MemWrite) begin
            mem_q[word_idx] <= bus.WriteData;
        end
    end

    assign bus.ReadData = (bus.MemRead && !Reset) ? mem_q[word_idx] : '0;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Scoreboard bench for alu_mem_stage: directed cases plus random traffic checked
// against an arithmetic reference model and a shadow memory.
module tb_alu_mem_stage;
    import cpu16_pkg::*;

    localparam int MEM_WORDS = 128;

    logic clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 clk = ~clk;

    alu_mem_stage_if bus ();

    alu_mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
        .Clock (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        string       nm;
        logic [3:0]  ctrl;
        logic [15:0] res;
        logic        z;
        logic        v;
        logic        c;
        logic [15:0] rd;
        int          idx;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] ref_mem [MEM_WORDS];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pend_we  = 1'b0;
    int          pend_idx = 0;
    logic [15:0] pend_wd  = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(string nm, logic [1:0] op, logic [1:0] fn, logic [3:0] opc,
                                   logic [15:0] a, logic [15:0] b, logic cin,
                                   logic mr, logic rst);
        exp_t e;
        int ua, ub, sa, sb, s, ss;
        e.nm = nm;
        e.v  = 1'b0;
        e.c  = 1'b0;
        e.res = '0;
        case (op)
            2'b00: e.ctrl = 4'b0010;
            2'b01: e.ctrl = 4'b0110;
            2'b10: begin
                case (fn)
                    2'b00:   e.ctrl = 4'b0010;
                    2'b01:   e.ctrl = 4'b0110;
                    2'b10:   e.ctrl = 4'b0000;
                    default: e.ctrl = 4'b0001;
                endcase
            end
            default: begin
                case (opc)
                    4'b0100: e.ctrl = 4'b0000;
                    4'b0101: e.ctrl = 4'b0001;
                    4'b0110: e.ctrl = 4'b0011;
                    4'b0111: e.ctrl = 4'b0111;
                    4'b1000: e.ctrl = 4'b1100;
                    default: e.ctrl = 4'b0010;
                endcase
            end
        endcase
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (e.ctrl)
            4'b0010: begin
                s     = ua + ub + int'(cin);
                ss    = sa + sb + int'(cin);
                e.res = 16'(s);
                e.c   = (s > 65535);
                e.v   = (ss > 32767) || (ss < -32768);
            end
            4'b0110: begin
                ss    = sa - sb;
                e.res = 16'(ua - ub);
                e.c   = (ua >= ub);
                e.v   = (ss > 32767) || (ss < -32768);
            end
            4'b0111: e.res = (sa < sb) ? 16'h0001 : 16'h0000;
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0011: e.res = a ^ b;
            default: e.res = ~(a | b);
        endcase
        e.z   = (e.res == 16'h0000);
        e.idx = (int'(e.res) >> 1) % MEM_WORDS;
        e.rd  = (mr && !rst) ? ref_mem[e.idx] : 16'h0000;
        return e;
    endfunction

    // One transaction per cycle: apply the previous store to the shadow memory at the
    // edge, then drive new inputs just after it and queue the expected response.
    task automatic issue(string nm, logic [1:0] op, logic [1:0] fn, logic [3:0] opc,
                         logic [15:0] a, logic [15:0] b, logic cin,
                         logic mw, logic mr, logic [15:0] wd, logic rst);
        exp_t e;
        @(posedge clk);
        if (pend_we) ref_mem[pend_idx] = pend_wd;
        #1;
        bus.ALUOp     = op;
        bus.Funct     = fn;
        bus.Opcode    = opc;
        bus.A         = a;
        bus.B         = b;
        bus.CarryIn   = cin;
        bus.MemWrite  = mw;
        bus.MemRead   = mr;
        bus.WriteData = wd;
        Reset         = rst;
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 16'h0000;
        end
        e = model(nm, op, fn, opc, a, b, cin, mr, rst);
        sbq.push_back(e);
        pend_we  = mw && !rst;
        pend_idx = e.idx;
        pend_wd  = wd;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({e.nm, "/ALUCtrl"},  32'(bus.ALUCtrl),  32'(e.ctrl));
                chk({e.nm, "/Result"},   32'(bus.Result),   32'(e.res));
                chk({e.nm, "/Zero"},     32'(bus.Zero),     32'(e.z));
                chk({e.nm, "/Overflow"}, 32'(bus.Overflow), 32'(e.v));
                chk({e.nm, "/CarryOut"}, 32'(bus.CarryOut), 32'(e.c));
                chk({e.nm, "/ReadData"}, 32'(bus.ReadData), 32'(e.rd));
            end
        end
    end

    initial begin : stimulus
        logic [1:0]  op, fn;
        logic [3:0]  opc;
        logic [15:0] a, b, wd;
        logic        cin, mw, mr;

        bus.ALUOp = '0; bus.Funct = '0; bus.Opcode = '0; bus.A = '0; bus.B = '0;
        bus.CarryIn = 1'b0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.WriteData = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 16'h0000;

        issue("reset",   2'b00, 2'b00, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        issue("add_ovf", 2'b10, 2'b00, 4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("sub_eq",  2'b01, 2'b00, 4'h0, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("slt_t",   2'b11, 2'b00, 4'h7, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("slt_f",   2'b11, 2'b00, 4'h7, 16'h0002, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("nor",     2'b11, 2'b00, 4'h8, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("imm_def", 2'b11, 2'b00, 4'hF, 16'h00F0, 16'h0F00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("add_cin", 2'b00, 2'b00, 4'h0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("sub_brw", 2'b10, 2'b01, 4'h0, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        issue("st_beef", 2'b00, 2'b00, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        issue("ld_beef", 2'b00, 2'b00, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        issue("ld_odd",  2'b00, 2'b00, 4'h0, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        issue("ld_wrap", 2'b00, 2'b00, 4'h0, 16'h0110, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        issue("ld_off",  2'b00, 2'b00, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        issue("rw_same", 2'b00, 2'b00, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1357, 1'b0);
        issue("ld_new",  2'b00, 2'b00, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);

        issue("st_a5a5", 2'b00, 2'b00, 4'h0, 16'h0006, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hA5A5, 1'b0);
        issue("ld_a5a5", 2'b00, 2'b00, 4'h0, 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        issue("rst_wr",  2'b00, 2'b00, 4'h0, 16'h0006, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1);
        issue("ld_clr",  2'b00, 2'b00, 4'h0, 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        issue("ld_clr2", 2'b00, 2'b00, 4'h0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                op  = 2'b00;
                fn  = 2'($urandom);
                opc = 4'($urandom);
                a   = 16'($urandom_range(255, 0));
                b   = 16'h0000;
                cin = 1'b0;
            end else begin
                op  = 2'($urandom);
                fn  = 2'($urandom);
                opc = 4'($urandom);
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = 1'($urandom);
            end
            mw = ($urandom_range(2, 0) == 0);
            mr = 1'($urandom);
            wd = 16'($urandom);
            issue("rnd", op, fn, opc, a, b, cin, mw, mr, wd, 1'b0);
        end

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending responses required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mem_stage.md
# alu_mem_stage

Execute-and-memory stage of the 16-bit single-cycle CPU datapath. It decodes `ALUOp`, `Funct` and `Opcode` into a 4-bit ALU control code, performs the 16-bit ALU operation with flags, and uses the ALU result as the address into a word-organised data memory. It sits between the register file and the write-back mux, alongside the shifter.

## Interface
- `MEM_WORDS`, default 128: number of 16-bit words in data memory.
- `Clock`: in, 1 bit, rising-edge clock.
- `Reset`: in, 1 bit. One clock; reset is asynchronous and active-high.
- `ALUOp`: in, 2 bits, main-decoder class (00 add, 01 sub, 10 R-type, 11 immediate).
- `Funct`: in, 2 bits, instruction[1:0].
- `Opcode`: in, 4 bits, instruction[15:12].
- `A`: in, 16 bits, operand A (rs data).
- `B`: in, 16 bits, operand B (rt data or sign-extended immediate).
- `CarryIn`: in, 1 bit, carry into ADD only.
- `MemWrite`: in, 1 bit, write strobe.
- `MemRead`: in, 1 bit, read enable.
- `WriteData`: in, 16 bits, store data (rt data).
- `ALUCtrl`: out, 4 bits, decoded ALU operation.
- `Result`: out, 16 bits, ALU result; also the memory address.
- `Zero`: out, 1 bit, high when `Result` is 16'h0000.
- `Overflow`: out, 1 bit, signed overflow.
- `CarryOut`: out, 1 bit, carry or no-borrow.
- `ReadData`: out, 16 bits, memory read data.

## Operation
- ALU control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, NOR 1100.
- Decode by `ALUOp`:
  - 00 → ADD.
  - 01 → SUB.
  - 10 → by `Funct`: 00 ADD, 01 SUB, 10 AND, 11 OR.
  - 11 → by `Opcode`: 0100 AND, 0101 OR, 0110 XOR, 0111 SLT, 1000 NOR; any other opcode → ADD.
- ADD: {CarryOut, Result} = A + B + CarryIn. Overflow when A and B have the same sign and Result's sign differs.
- SUB: {CarryOut, Result} = A + ~B + 1; `CarryIn` is ignored. CarryOut=1 means no borrow. Overflow when A and B have different signs and Result's sign differs from A's.
- SLT: Result = 16'h0001 if A < B as signed (sign of A−B XOR overflow of A−B), else 16'h0000. CarryOut and Overflow are 0.
- AND, OR, XOR, NOR: bitwise; CarryOut and Overflow are 0.
- Undefined `ALUCtrl` codes: Result 0, CarryOut 0, Overflow 0, so Zero = 1.
- Zero is computed on the final Result for every operation.
- Memory is byte-addressed with word access:
  - Word index = Result[k:1], where k = log2(MEM_WORDS). Result[0] and bits above k are ignored, so addresses wrap.
  - Write: on rising `Clock`, if `MemWrite` and not `Reset`, mem[index] ← WriteData.
  - Read: combinational. ReadData = mem[index] when `MemRead`, else 16'h0000.
  - `MemRead` and `MemWrite` both high in the same cycle: ReadData shows the old word until the edge, then the new word.
- Reset: asynchronously clears every memory word to 0. While `Reset` is high, ReadData = 0 and writes are blocked. The ALU and decoder are purely combinational and unaffected by reset.

## Timing
- Decoder and ALU: zero latency, combinational from inputs.
- Store: one clock edge. Load: combinational from address, no wait states, no handshake.
- Reset assertion mid-cycle clears memory immediately; a write coinciding with reset deassertion at the same edge is dropped.

## Structure
- Shared package `cpu16_pkg`: ALU control code constants, ALUOp constants, opcode constants (ANDI, ORI, XORI, SLTI, NORI), and the word width (16).
- Natural sub-module: `alu16_core`, holding the ALU with its flags. Decoder and memory stay inline in `alu_mem_stage`.

## Test plan
- ALUOp=10, Funct=00, A=16'h7FFF, B=16'h0001, CarryIn=0 → ALUCtrl=0010, Result=16'h8000, Overflow=1, CarryOut=0, Zero=0.
- ALUOp=01, A=B=16'h1234 → ALUCtrl=0110, Result=0, Zero=1, CarryOut=1, Overflow=0.
- ALUOp=11, Opcode=0111, A=16'hFFFF, B=16'h0001 → ALUCtrl=0111, Result=16'h0001. Repeat with A=16'h0002, B=16'hFFFE → Result=0, Zero=1.
- ALUOp=11, Opcode=1000, A=16'h00F0, B=16'h0F00 → ALUCtrl=1100, Result=16'hF00F. Repeat with Opcode=1111 → ALUCtrl=0010.
- Store then load:
  - A=16'h0010, B=0, ALUOp=00, MemWrite=1, WriteData=16'hBEEF, one edge.
  - Then MemWrite=0, MemRead=1 → ReadData=16'hBEEF.
  - Address 16'h0011 reads the same word.
  - MemRead=0 → ReadData=0.
- Write 16'hA5A5 to word 3, pulse `Reset` between edges → ReadData at word 3 reads 0 immediately. A write attempted during `Reset` is lost.
